// File: rtl/d_frame_check.sv
// Frame checker downstream of the d-engine: validates frame length and framing,
// tags each forwarded word with its section, and extracts the per-frame saturation counts.
module d_frame_check #(
  parameter int unsigned DATA_LEN  = 1024,
  parameter int unsigned TRUNK_LEN = 16
) (
  input  logic        clk,
  input  logic        rstf,
  input  logic [31:0] t_data,
  input  logic        t_last,
  input  logic        t_valid,
  output logic        t_ready,
  output logic [31:0] i_data,
  output logic [1:0]  i_section,
  output logic        i_last,
  output logic        i_valid,
  input  logic        i_ready,
  input  logic [31:0] sat_limit,
  output logic [31:0] func0_sat,
  output logic [31:0] func1_sat,
  output logic        sat_alarm,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_short,
  output logic [15:0] err_long,
  output logic        in_sync
);

  localparam int unsigned MAXL = (DATA_LEN > TRUNK_LEN) ? DATA_LEN : TRUNK_LEN;
  localparam int unsigned CW   = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] DLAST = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0] TLAST = CW'(TRUNK_LEN - 1);
  localparam logic [CW-1:0] TPEN  = CW'(TRUNK_LEN - 2);

  typedef enum logic [2:0] {
    S_SYNC,
    S_DATA,
    S_FUNC0,
    S_FUNC1,
    S_TRUNK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pend0_q, pend0_d;
  logic [31:0]   f0_q, f0_d, f1_q, f1_d;
  logic          alarm_q, alarm_d;
  logic [31:0]   fcnt_q, fcnt_d;
  logic [15:0]   es_q, es_d, el_q, el_d;

  logic [31:0]   od_q;
  logic [1:0]    osec_q;
  logic          olast_q, ov_q;

  logic          xfer;
  logic          fwd;
  logic [1:0]    sec;
  logic          sec_last;

  assign t_ready = ~ov_q | i_ready;
  assign xfer    = t_valid & t_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend0_d  = pend0_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    alarm_d  = alarm_q;
    fcnt_d   = fcnt_q;
    es_d     = es_q;
    el_d     = el_q;
    fwd      = 1'b0;
    sec      = 2'd0;
    sec_last = 1'b0;
    if (xfer) begin
      case (state_q)
        S_SYNC: begin
          if (t_last) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA, S_FUNC0, S_FUNC1: begin
          fwd = 1'b1;
          case (state_q)
            S_DATA:  sec = 2'd0;
            S_FUNC0: sec = 2'd1;
            default: sec = 2'd2;
          endcase
          if (t_last) begin
            sec_last = 1'b1;
            state_d  = S_DATA;
            cnt_d    = '0;
            if (es_q != '1) es_d = es_q + 16'd1;
          end else if (cnt_q == DLAST) begin
            sec_last = 1'b1;
            cnt_d    = '0;
            case (state_q)
              S_DATA:  state_d = S_FUNC0;
              S_FUNC0: state_d = S_FUNC1;
              default: state_d = S_TRUNK;
            endcase
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_TRUNK: begin
          fwd = 1'b1;
          sec = 2'd3;
          if (cnt_q == TPEN) pend0_d = t_data;
          if (cnt_q == TLAST) begin
            sec_last = 1'b1;
            cnt_d    = '0;
            if (t_last) begin
              // good frame: publish counts, threshold sampled on this transfer only
              f0_d    = pend0_q;
              f1_d    = t_data;
              alarm_d = (pend0_q > sat_limit) | (t_data > sat_limit);
              fcnt_d  = fcnt_q + 32'd1;
              state_d = S_DATA;
            end else begin
              if (el_q != '1) el_d = el_q + 16'd1;
              state_d = S_SYNC;
            end
          end else if (t_last) begin
            sec_last = 1'b1;
            cnt_d    = '0;
            state_d  = S_DATA;
            if (es_q != '1) es_d = es_q + 16'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_SYNC;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q <= S_SYNC;
      cnt_q   <= '0;
      pend0_q <= '0;
      f0_q    <= '0;
      f1_q    <= '0;
      alarm_q <= 1'b0;
      fcnt_q  <= '0;
      es_q    <= '0;
      el_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend0_q <= pend0_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      alarm_q <= alarm_d;
      fcnt_q  <= fcnt_d;
      es_q    <= es_d;
      el_q    <= el_d;
    end
  end

  // Output slice: reloads whenever it can accept, holds while stalled
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      ov_q    <= 1'b0;
      od_q    <= '0;
      osec_q  <= '0;
      olast_q <= 1'b0;
    end else if (t_ready) begin
      ov_q <= xfer & fwd;
      if (xfer & fwd) begin
        od_q    <= t_data;
        osec_q  <= sec;
        olast_q <= sec_last;
      end
    end
  end

  assign i_valid   = ov_q;
  assign i_data    = od_q;
  assign i_section = osec_q;
  assign i_last    = olast_q;
  assign func0_sat = f0_q;
  assign func1_sat = f1_q;
  assign sat_alarm = alarm_q;
  assign frame_cnt = fcnt_q;
  assign err_short = es_q;
  assign err_long  = el_q;
  assign in_sync   = (state_q != S_SYNC);

endmodule

// File: tb/tb_d_frame_check.sv
// Randomized bench for d_frame_check against a frame-position reference model.
module tb_d_frame_check;

  localparam int unsigned DL = 1024;
  localparam int unsigned TL = 16;
  localparam int unsigned FL = 3 * DL + TL;

  logic        clk = 1'b0;
  logic        rstf = 1'b0;
  logic [31:0] t_data = '0;
  logic        t_last = 1'b0;
  logic        t_valid = 1'b0;
  logic        t_ready;
  logic [31:0] i_data;
  logic [1:0]  i_section;
  logic        i_last;
  logic        i_valid;
  logic        i_ready = 1'b1;
  logic [31:0] sat_limit = '0;
  logic [31:0] func0_sat, func1_sat, frame_cnt;
  logic        sat_alarm, in_sync;
  logic [15:0] err_short, err_long;

  always #5 clk = ~clk;

  d_frame_check #(.DATA_LEN(DL), .TRUNK_LEN(TL)) dut (
    .clk(clk), .rstf(rstf),
    .t_data(t_data), .t_last(t_last), .t_valid(t_valid), .t_ready(t_ready),
    .i_data(i_data), .i_section(i_section), .i_last(i_last),
    .i_valid(i_valid), .i_ready(i_ready),
    .sat_limit(sat_limit),
    .func0_sat(func0_sat), .func1_sat(func1_sat), .sat_alarm(sat_alarm),
    .frame_cnt(frame_cnt), .err_short(err_short), .err_long(err_long),
    .in_sync(in_sync)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: a frame is FL words; section and section-end follow from position alone
  logic [34:0] expq[$];
  bit          m_sync = 1'b0;
  int unsigned m_pos = 0;
  logic [31:0] m_p0 = '0, m_f0 = '0, m_f1 = '0, m_fc = '0;
  bit          m_alarm = 1'b0;
  int unsigned m_es = 0, m_el = 0;

  function automatic void model_accept(input logic [31:0] d, input logic l);
    int unsigned s;
    bit fin, sl;
    if (!m_sync) begin
      if (l) begin
        m_sync = 1'b1;
        m_pos  = 0;
      end
      return;
    end
    s   = (m_pos < 3 * DL) ? m_pos / DL : 3;
    fin = (m_pos == FL - 1);
    sl  = fin || l || (m_pos < 3 * DL && (m_pos % DL) == DL - 1);
    expq.push_back({d, s[1:0], sl});
    if (m_pos == FL - 2) m_p0 = d;
    if (fin && l) begin
      m_f0    = m_p0;
      m_f1    = d;
      m_alarm = (m_p0 > sat_limit) || (d > sat_limit);
      m_fc    = m_fc + 1;
      m_pos   = 0;
    end else if (fin) begin
      if (m_el < 65535) m_el++;
      m_sync = 1'b0;
      m_pos  = 0;
    end else if (l) begin
      if (m_es < 65535) m_es++;
      m_pos = 0;
    end else begin
      m_pos++;
    end
  endfunction

  bit rnd_ready = 1'b0;
  initial forever begin
    @(negedge clk);
    i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  bit          mon_en = 1'b0;
  bit          held = 1'b0;
  logic [34:0] held_v;
  initial forever begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (held)
        check("hold_stable", {i_valid, i_data, i_section, i_last}, {1'b1, held_v});
      if (i_valid && i_ready) begin
        if (expq.size() == 0)
          check("extra_out", 64'(expq.size()), 64'd1);
        else
          check("out_word", {i_data, i_section, i_last}, expq.pop_front());
      end
      held   = i_valid && !i_ready;
      held_v = {i_data, i_section, i_last};
    end else begin
      held = 1'b0;
    end
  end

  int unsigned stall_cnt = 0;

  task automatic send_word(input logic [31:0] d, input logic l);
    int unsigned n = 0;
    bit acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      t_valid = 1'b1;
      t_data  = d;
      t_last  = l;
      #1;
      acc = t_ready;
      @(posedge clk);
      n++;
    end
    if (acc) model_accept(d, l);
    else check("accept_timeout", 64'(acc), 64'd1);
    stall_cnt += n - 1;
  endtask

  task automatic send_frame(input logic [31:0] f0, input logic [31:0] f1,
                            input int short_at, input bit no_last,
                            input int unsigned first, input int unsigned upto);
    logic [31:0] d;
    logic l;
    for (int unsigned p = first; p < upto; p++) begin
      d = (p == FL - 2) ? f0 : (p == FL - 1) ? f1 : $urandom;
      l = (int'(p) == short_at) || (p == FL - 1 && !no_last);
      send_word(d, l);
      if (int'(p) == short_at) break;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    @(negedge clk);
    t_valid = 1'b0;
    t_last  = 1'b0;
    while ((expq.size() != 0 || i_valid) && n < 2000) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_bound", 64'(n < 2000), 64'd1);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_func0_sat"}, func0_sat, m_f0);
    check({tag, "_func1_sat"}, func1_sat, m_f1);
    check({tag, "_sat_alarm"}, sat_alarm, m_alarm);
    check({tag, "_frame_cnt"}, frame_cnt, m_fc);
    check({tag, "_err_short"}, err_short, 16'(m_es));
    check({tag, "_err_long"}, err_long, 16'(m_el));
    check({tag, "_in_sync"}, in_sync, m_sync);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_i_valid"}, i_valid, 1'b0);
    check({tag, "_i_word"}, {i_data, i_section, i_last}, 35'd0);
    check({tag, "_sats"}, {func0_sat, func1_sat, sat_alarm}, 65'd0);
    check({tag, "_counts"}, {frame_cnt, err_short, err_long}, 64'd0);
    check({tag, "_in_sync"}, in_sync, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_t_ready", t_ready, 1'b1);
    rstf   = 1'b1;
    mon_en = 1'b1;

    // Sync-up: four unmarked words then one with last, all dropped
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
    #1 check("presync_in_sync", in_sync, 1'b0);
    send_word($urandom, 1'b1);
    #1 check("sync_in_sync", in_sync, 1'b1);
    check("sync_no_output", i_valid, 1'b0);

    // First good frame at full rate: 1-cycle latency, no stalls
    sat_limit = 32'd5;
    stall_cnt = 0;
    send_word(32'hA5A5_0001, 1'b0);
    #1 check("latency", {i_valid, i_data}, {1'b1, 32'hA5A5_0001});
    send_frame(32'd3, 32'd7, -1, 1'b0, 1, FL);
    check("full_rate_stalls", stall_cnt, 0);
    drain();
    check_status("good1");
    check("good1_alarm_exp", sat_alarm, 1'b1);

    sat_limit = 32'd7;
    send_frame(32'd3, 32'd7, -1, 1'b0, 0, FL);
    drain();
    check_status("limit7");
    send_frame(32'd8, 32'd7, -1, 1'b0, 0, FL);
    drain();
    check_status("f0_over");

    // Early last on func0 word 100, then recovery
    send_frame(32'd1, 32'd2, int'(DL + 100), 1'b0, 0, FL);
    drain();
    check_status("short");
    send_frame(32'd4, 32'd9, -1, 1'b0, 0, FL);
    drain();
    check_status("after_short");

    // Missing last: drop to SYNC, resync on next last
    send_frame(32'd11, 32'd12, -1, 1'b1, 0, FL);
    drain();
    check_status("long");
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    send_frame(32'd2, 32'd3, -1, 1'b0, 0, FL);
    drain();
    check_status("after_long");

    // Backpressure with continuous t_valid
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      sat_limit = $urandom_range(0, 20);
      send_frame($urandom_range(0, 20), $urandom_range(0, 20), -1, 1'b0, 0, FL);
    end
    drain();
    check_status("random_ready");
    rnd_ready = 1'b0;

    // Reset mid-FUNC1
    send_frame(32'd0, 32'd0, -1, 1'b0, 0, 2 * DL + 50);
    @(negedge clk);
    mon_en  = 1'b0;
    t_valid = 1'b0;
    t_last  = 1'b0;
    #3 rstf = 1'b0;
    #1 check_zero_outputs("midreset");
    expq.delete();
    m_sync = 1'b0; m_pos = 0; m_p0 = '0; m_f0 = '0; m_f1 = '0;
    m_fc = '0; m_alarm = 1'b0; m_es = 0; m_el = 0;
    repeat (3) @(negedge clk);
    rstf   = 1'b1;
    mon_en = 1'b1;
    send_word($urandom, 1'b1);
    sat_limit = 32'd10;
    send_frame(32'd6, 32'd15, -1, 1'b0, 0, FL);
    drain();
    check_status("post_reset");
    check("post_reset_frame_cnt", frame_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/d_frame_check.md
Name: d_frame_check

Overview:
- Sits directly downstream of the d-engine processing stage and consumes its result stream.
- Each input frame is DATA_LEN raw words, then DATA_LEN func0 results, then DATA_LEN func1 results, then TRUNK_LEN trunk words. The last two trunk words carry the func0 and func1 saturation counts. Input last marks the final trunk word.
- The block checks frame framing and length, tags each forwarded word with its section, and marks section ends.
- It extracts the saturation counts into status outputs and raises an alarm when either count exceeds a limit.

Parameters:
DATA_LEN, 1024, words per data/func0/func1 section
TRUNK_LEN, 16, trunk words per frame (>=2; last two are sat counts)

Ports:
clk  in  1  clock
rstf  in  1  asynchronous active-low reset
t_data  in  32  input word
t_last  in  1  end-of-frame marker from upstream
t_valid  in  1  input valid
t_ready  out  1  input ready
i_data  out  32  forwarded word
i_section  out  2  0=data, 1=func0, 2=func1, 3=trunk
i_last  out  1  last word of current section
i_valid  out  1  output valid
i_ready  in  1  output ready
sat_limit  in  32  alarm threshold, unsigned
func0_sat  out  32  func0 sat count of last good frame
func1_sat  out  32  func1 sat count of last good frame
sat_alarm  out  1  last good frame had a sat count > sat_limit
frame_cnt  out  32  good frames received, wraps
err_short  out  16  frames ended early (t_last before expected end), saturating
err_long  out  16  frames missing t_last at expected end, saturating
in_sync  out  1  high when not in SYNC state

Behaviour:
- Reset:
  - All outputs are 0. Internal state is SYNC, with word counter 0 and pending sat regs 0.
  - Reset mid-frame aborts the frame. The output register is cleared, so no partial word leaks out.
- Output stage is one register slice:
  - t_ready = ~i_valid | i_ready.
  - Latency from input accept to i_valid is 1 cycle. Full throughput at 1 word/cycle under continuous ready.
  - i_data, i_section and i_last hold stable while i_valid & ~i_ready.
- An input transfer is t_valid & t_ready. All counting and state changes occur only on transfers.
- States: SYNC, DATA, FUNC0, FUNC1, TRUNK. The counter is 0 on entry to each state.
- SYNC:
  - t_ready = 1 and words are dropped; nothing is forwarded.
  - A transfer with t_last -> DATA.
- DATA, FUNC0, FUNC1:
  - Each word is forwarded with section 0/1/2.
  - At counter == DATA_LEN-1, the word is forwarded with i_last=1 and the state advances: DATA->FUNC0->FUNC1->TRUNK.
- TRUNK:
  - Each word is forwarded with section 3.
  - Word TRUNK_LEN-2 is latched into pending0. Word TRUNK_LEN-1 is the func1 count (pending1).
  - At counter == TRUNK_LEN-1, the word is forwarded with i_last=1.
- Good frame: the TRUNK final word arrives with t_last=1. On that same transfer:
  - func0_sat <= pending0.
  - func1_sat <= that word.
  - sat_alarm <= (pending0 > sat_limit) | (word > sat_limit), unsigned compare.
  - frame_cnt increments.
  - Next state is DATA.
- Early last: t_last=1 on any word that is not the final trunk word.
  - The word is forwarded with i_last=1 and err_short increments.
  - Next state is DATA, treating the next word as a new frame start.
  - Status outputs and frame_cnt are unchanged.
- Missing last: the final trunk word arrives with t_last=0.
  - The word is forwarded with i_last=1 and err_long increments.
  - Next state is SYNC. Status outputs are unchanged.
- Error counters saturate at 16'hFFFF. frame_cnt wraps at 2^32.
- sat_limit is sampled on the good-frame transfer. Changing it mid-frame has no other effect.
- in_sync = (state != SYNC).

Test Plan:
- Stream 5 words with the 5th carrying t_last, then one good frame (DATA_LEN=1024, TRUNK_LEN=16) with trunk[14]=3, trunk[15]=7, and sat_limit=5.
  -> The 5 words are dropped and in_sync rises after the 5th.
  -> 3088 words are forwarded with i_last on words 1024, 2048, 3072 and 3088, and sections 0/1/2/3 in order.
  -> func0_sat=3, func1_sat=7, sat_alarm=1, frame_cnt=1.
- Same frame with sat_limit=7 -> sat_alarm=0. With trunk[14]=8 -> sat_alarm=1.
- t_last on func0 word 100 -> that word is forwarded with i_last=1 and err_short=1. The next good frame then yields frame_cnt+1 with no further errors.
- Final trunk word with t_last=0 -> err_long=1 and in_sync=0. Words are dropped until the next t_last, after which a good frame completes normally.
- Random i_ready (50%) with continuous t_valid over 3 frames -> no word is lost or duplicated, and output data stays stable while stalled. With i_ready=1 throughout, there is 1 word/cycle after 1-cycle latency.
- Assert rstf low mid-FUNC1 -> all outputs are 0 immediately, including i_valid. After release the state is SYNC, and a subsequent t_last followed by a good frame gives frame_cnt=1.
